// File: rtl/input_conditioner.sv
// Conditions active-low pad inputs: per-channel synchroniser, debounce filter, press/release pulses.
// Optional long-press detection is built when INPUT_COND_LONG_PRESS_EN is defined.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 164,
  parameter int LONG_CYCLES     = 32768
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] nRawIn,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] LongPress
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : gChkSync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gChkDebounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_CYCLES < 2) begin : gChkLong
    $error("LONG_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] syncQ   [CHANNELS];
  logic [CNT_W-1:0]       cnt     [CHANNELS];
  logic [CNT_W-1:0]       cntNext [CHANNELS];
  logic [CHANNELS-1:0]    syncLevel;
  logic [CHANNELS-1:0]    accept;

  // A channel is pending while its synchronised level disagrees with Level;
  // any agreement before the count completes drops the count (glitch rejected).
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      syncLevel[ch] = ~syncQ[ch][SYNC_STAGES-1];
      accept[ch]    = (syncLevel[ch] != Level[ch]) && (cnt[ch] == CNT_LAST);
      if ((syncLevel[ch] == Level[ch]) || accept[ch]) begin
        cntNext[ch] = '0;
      end else begin
        cntNext[ch] = cnt[ch] + 1'b1;
      end
    end
  end

  // Synchroniser shift and debounce state update
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        syncQ[ch] <= '1;
        cnt[ch]   <= '0;
      end
      Level   <= '0;
      Press   <= '0;
      Release <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        syncQ[ch] <= {syncQ[ch][SYNC_STAGES-2:0], nRawIn[ch]};
        cnt[ch]   <= cntNext[ch];
      end
      // Acceptance only happens on disagreement, so it is a toggle of Level.
      Level   <= Level ^ accept;
      Press   <= accept & syncLevel;
      Release <= accept & ~syncLevel;
    end
  end

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_TRIG = HOLD_W'(LONG_CYCLES - 2);

  logic [HOLD_W-1:0] holdCnt [CHANNELS];

  // Hold counter; the pulse is registered alongside the step to LONG_CYCLES-1
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        holdCnt[ch] <= '0;
      end
      LongPress <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!Level[ch]) begin
          holdCnt[ch] <= '0;
        end else if (holdCnt[ch] != HOLD_SAT) begin
          holdCnt[ch] <= holdCnt[ch] + 1'b1;
        end
        LongPress[ch] <= Level[ch] && (holdCnt[ch] == HOLD_TRIG);
      end
    end
  end
`else
  assign LongPress = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed table plus randomised model comparison for input_conditioner
// (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic       Clock;
  logic       Reset;
  logic [3:0] nRawIn;
  logic [3:0] Level, Press, Release, LongPress;

  input_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .Clock(Clock), .Reset(Reset), .nRawIn(nRawIn),
    .Level(Level), .Press(Press), .Release(Release), .LongPress(LongPress)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Window model: a channel flips once the last DEB synchronised samples
  // all disagree with its current level.
  logic [3:0] mPipe0, mPipe1;
  logic [3:0] mHist [DEB];
  logic [3:0] mLevel, mPress, mRelease, mLong;
  int         mHigh [4];

  task automatic modelEdge();
    logic [3:0] s;
    logic [3:0] prevLevel;
    logic       allDiff;
    if (Reset) begin
      mPipe0 = '1; mPipe1 = '1;
      for (int i = 0; i < DEB; i++) mHist[i] = '0;
      mLevel = '0; mPress = '0; mRelease = '0; mLong = '0;
      for (int ch = 0; ch < 4; ch++) mHigh[ch] = 0;
    end else begin
      s = ~mPipe1;
      for (int i = DEB - 1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = s;
      prevLevel = mLevel;
      for (int ch = 0; ch < 4; ch++) begin
        allDiff = 1'b1;
        for (int i = 0; i < DEB; i++) if (mHist[i][ch] == mLevel[ch]) allDiff = 1'b0;
        mPress[ch]   = allDiff && s[ch];
        mRelease[ch] = allDiff && !s[ch];
        if (allDiff) mLevel[ch] = s[ch];
        if (prevLevel[ch]) mHigh[ch] = mHigh[ch] + 1;
        else mHigh[ch] = 0;
        mLong[ch] = (mHigh[ch] == LONG - 1);
      end
      mPipe1 = mPipe0;
      mPipe0 = nRawIn;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] raw);
    Reset  = rst;
    nRawIn = raw;
    @(posedge Clock);
    modelEdge();
    #1;
  endtask

  task automatic addN(input int n, input logic rst, input logic [3:0] raw,
                      input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    vec_t v;
    v.rst = rst; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = 4'h0;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] act, exp;
    logic [3:0]  rnd;
    logic [3:0]  expLong;
    int          runLeft [4];

    Reset  = 1'b1;
    nRawIn = 4'h0;

    // Reset with all pads pressed, then all four channels accept together
    addN(3, 1, 4'h0, 4'h0, 4'h0, 4'h0);    // rows 0-2
    addN(5, 0, 4'h0, 4'h0, 4'h0, 4'h0);    // rows 3-7
    addN(1, 0, 4'h0, 4'hF, 4'hF, 4'h0);    // row 8: first sample at row 3, +2+4-1
    addN(1, 0, 4'h0, 4'hF, 4'h0, 4'h0);
    addN(5, 0, 4'hF, 4'hF, 4'h0, 4'h0);    // rows 10-14
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'hF);    // row 15
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    // ch0: 3-cycle glitch rejected, then 4-cycle press accepted and released
    addN(3, 0, 4'hE, 4'h0, 4'h0, 4'h0);    // rows 17-19
    addN(4, 0, 4'hF, 4'h0, 4'h0, 4'h0);    // rows 20-23
    addN(4, 0, 4'hE, 4'h0, 4'h0, 4'h0);    // rows 24-27
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    addN(1, 0, 4'hF, 4'h1, 4'h1, 4'h0);    // row 29
    addN(3, 0, 4'hF, 4'h1, 4'h0, 4'h0);
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h1);    // row 33
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    // ch1+ch2 together, then releases one cycle apart
    addN(5, 0, 4'h9, 4'h0, 4'h0, 4'h0);    // rows 35-39
    addN(1, 0, 4'h9, 4'h6, 4'h6, 4'h0);    // row 40
    addN(1, 0, 4'hB, 4'h6, 4'h0, 4'h0);
    addN(4, 0, 4'hF, 4'h6, 4'h0, 4'h0);
    addN(1, 0, 4'hF, 4'h4, 4'h0, 4'h2);    // row 46
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h4);    // row 47
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    // ch3 reset while pending with cnt=2: the full window starts over
    addN(4, 0, 4'h7, 4'h0, 4'h0, 4'h0);    // rows 49-52
    addN(1, 1, 4'h7, 4'h0, 4'h0, 4'h0);    // row 53
    addN(5, 0, 4'h7, 4'h0, 4'h0, 4'h0);    // rows 54-58
    addN(1, 0, 4'h7, 4'h8, 4'h8, 4'h0);    // row 59
    addN(5, 0, 4'hF, 4'h8, 4'h0, 4'h0);    // rows 60-64
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h8);    // row 65
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    // ch0 long hold, then a 10-cycle hold
    addN(5, 0, 4'hE, 4'h0, 4'h0, 4'h0);    // rows 67-71
    addN(1, 0, 4'hE, 4'h1, 4'h1, 4'h0);    // row 72
    addN(23, 0, 4'hE, 4'h1, 4'h0, 4'h0);   // rows 73-95
    addN(5, 0, 4'hF, 4'h1, 4'h0, 4'h0);    // rows 96-100
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h1);    // row 101
    addN(5, 0, 4'hE, 4'h0, 4'h0, 4'h0);    // rows 102-106
    addN(1, 0, 4'hE, 4'h1, 4'h1, 4'h0);    // row 107
    addN(4, 0, 4'hE, 4'h1, 4'h0, 4'h0);
    addN(5, 0, 4'hF, 4'h1, 4'h0, 4'h0);    // rows 112-116
    addN(1, 0, 4'hF, 4'h0, 4'h0, 4'h1);    // row 117
    addN(8, 0, 4'hF, 4'h0, 4'h0, 4'h0);
`ifdef INPUT_COND_LONG_PRESS_EN
    vecs[87].lng = 4'h1;                   // Press at row 72, LongPress 15 cycles later
`endif

    for (int r = 0; r < vecs.size(); r++) begin
      step(vecs[r].rst, vecs[r].raw);
      act = {Level, Press, Release, LongPress};
      exp = {vecs[r].lvl, vecs[r].prs, vecs[r].rel, vecs[r].lng};
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("FAIL vec row %0d: got Level/Press/Release/LongPress=%h, want %h", r, act, exp);
      end
    end

    // Randomised runs compared against the window model
    rnd = 4'hF;
    for (int ch = 0; ch < 4; ch++) runLeft[ch] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 4; ch++) begin
        runLeft[ch]--;
        if (runLeft[ch] <= 0) begin
          rnd[ch] = ~rnd[ch];
          runLeft[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                    : int'($urandom_range(4, 24));
        end
      end
      step(1'b0, rnd);
`ifdef INPUT_COND_LONG_PRESS_EN
      expLong = mLong;
`else
      expLong = 4'h0;
`endif
      act = {Level, Press, Release, LongPress};
      exp = {mLevel, mPress, mRelease, expLong};
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("FAIL random cycle %0d: got Level/Press/Release/LongPress=%h, want %h", cyc, act, exp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
